// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_core
// Purpose  : mm:ss BCD stopwatch timekeeping core. Synchronises the divided
//            clock from the divider chain into the system clock domain, turns
//            its rising edges into single-cycle ticks, and gates those ticks
//            through an IDLE/RUN/PAUSE state machine into a cascaded BCD
//            counter that wraps at 59:59.
// Ports    : clock      - system clock, rising-edge active
//            rst        - asynchronous active-high reset
//            clk_in     - divided clock, asynchronous to clock
//            start_stop - debounced level, rising edge toggles run/pause
//            clear      - synchronous level, zeroes count and forces IDLE
//            running    - registered, high while in RUN
//            sec_lo     - seconds units (BCD 0-9)
//            sec_hi     - seconds tens  (BCD 0-5)
//            min_lo     - minutes units (BCD 0-9)
//            min_hi     - minutes tens  (BCD 0-5)
//            rollover   - registered one-cycle pulse on 59:59 -> 00:00
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       clk_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic       running,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       rollover
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] c_DIG_MAX9 = 4'd9;
  localparam logic [3:0] c_DIG_MAX5 = 4'd5;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_hist;
  logic                   r_ss_hist;
  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_tick;
  logic                   w_ss_edge;
  logic                   w_count_en;
  logic                   w_at_max;
  logic                   r_running;
  logic                   r_rollover;
  logic [3:0]             r_sec_lo;
  logic [3:0]             r_sec_hi;
  logic [3:0]             r_min_lo;
  logic [3:0]             r_min_hi;

  // Synchroniser chain plus history flops. The start_stop history keeps
  // updating while clear is high, so a level still held when clear drops
  // is not mistaken for a fresh edge.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_sync      <= '0;
      r_sync_hist <= 1'b0;
      r_ss_hist   <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], clk_in};
      r_sync_hist <= r_sync[SYNC_STAGES-1];
      r_ss_hist   <= start_stop;
    end
  end

  assign w_tick     = r_sync[SYNC_STAGES-1] & ~r_sync_hist;
  assign w_ss_edge  = start_stop & ~r_ss_hist;
  assign w_count_en = (r_state == S_RUN) & w_tick & ~clear;
  assign w_at_max   = (r_sec_lo == c_DIG_MAX9) && (r_sec_hi == c_DIG_MAX5) &&
                      (r_min_lo == c_DIG_MAX9) && (r_min_hi == c_DIG_MAX5);

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == S_RUN);
    end
  end

  // Next-state logic. A tick coincident with the toggle out of RUN is still
  // counted because w_count_en looks at the current state, not the next.
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = S_IDLE;
    end else if (w_ss_edge) begin
      case (r_state)
        S_IDLE:  w_state_next = S_RUN;
        S_RUN:   w_state_next = S_PAUSE;
        S_PAUSE: w_state_next = S_RUN;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Cascaded BCD counter
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_sec_lo   <= 4'd0;
      r_sec_hi   <= 4'd0;
      r_min_lo   <= 4'd0;
      r_min_hi   <= 4'd0;
      r_rollover <= 1'b0;
    end else if (clear) begin
      r_sec_lo   <= 4'd0;
      r_sec_hi   <= 4'd0;
      r_min_lo   <= 4'd0;
      r_min_hi   <= 4'd0;
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= w_count_en & w_at_max;
      if (w_count_en) begin
        if (r_sec_lo >= c_DIG_MAX9) begin
          r_sec_lo <= 4'd0;
          if (r_sec_hi >= c_DIG_MAX5) begin
            r_sec_hi <= 4'd0;
            if (r_min_lo >= c_DIG_MAX9) begin
              r_min_lo <= 4'd0;
              if (r_min_hi >= c_DIG_MAX5) begin
                r_min_hi <= 4'd0;
              end else begin
                r_min_hi <= r_min_hi + 4'd1;
              end
            end else begin
              r_min_lo <= r_min_lo + 4'd1;
            end
          end else begin
            r_sec_hi <= r_sec_hi + 4'd1;
          end
        end else begin
          r_sec_lo <= r_sec_lo + 4'd1;
        end
      end
    end
  end

  assign running  = r_running;
  assign rollover = r_rollover;
  assign sec_lo   = r_sec_lo;
  assign sec_hi   = r_sec_hi;
  assign min_lo   = r_min_lo;
  assign min_hi   = r_min_hi;

endmodule
`default_nettype wire

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping core that consumes the divided 1 Hz-class clock produced by the stopwatch clock divider and turns it into a running mm:ss count in BCD. The divided clock is treated as an asynchronous data input: it is synchronised into the system `clock` domain and edge-detected into single-cycle ticks. A run/pause/idle state machine gates the ticks into a cascaded BCD counter that wraps at 59:59. The outputs drive the display path directly.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages in the `clk_in` synchroniser. Legal values are 2 and above.
- `clock` in 1: system clock. All state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clk_in` in 1: divided clock from the divider chain, asynchronous to `clock`. Its high and low phases are each at least `SYNC_STAGES`+1 `clock` cycles.
- `start_stop` in 1: already-debounced, synchronous level. Each rising edge toggles run/pause.
- `clear` in 1: synchronous level. While high, the count is zeroed and the state is forced to IDLE.
- `running` out 1: high when in RUN.
- `sec_lo` out 4: seconds units, BCD 0–9.
- `sec_hi` out 4: seconds tens, BCD 0–5.
- `min_lo` out 4: minutes units, BCD 0–9.
- `min_hi` out 4: minutes tens, BCD 0–5.
- `rollover` out 1: one-cycle pulse on the 59:59 → 00:00 wrap.

## Operation
- Synchroniser: `clk_in` passes through `SYNC_STAGES` flops, then one history flop. `tick` is internal and equals last sync stage AND NOT history, so each rising edge of `clk_in` produces exactly one tick. Falling edges produce nothing.
- `start_stop` edge detect: one history flop. `ss_edge` = `start_stop` AND NOT history.
- FSM states:
  - IDLE: reset state, count is zero.
  - RUN: ticks advance the count.
  - PAUSE: count held.
- FSM transitions:
  - IDLE → RUN on `ss_edge`.
  - RUN → PAUSE on `ss_edge`.
  - PAUSE → RUN on `ss_edge`.
  - Any state → IDLE when `clear` is high.
- Counting happens only when state is RUN and `tick` is high. Each tick adds 1 second in BCD:
  - `sec_lo` 9 → 0 carries into `sec_hi`.
  - `sec_hi` 5 → 0 carries into `min_lo`.
  - `min_lo` 9 → 0 carries into `min_hi`.
  - `min_hi` 5 with full carry → 0.
- 59:59 plus a tick gives 00:00, `rollover` = 1 for that one cycle, and the block stays in RUN.
- Digits never take values outside their BCD ranges.
- Precedence within a cycle, highest first: `clear`, then count, then FSM toggle.
  - `clear` high: zeros the count and forces IDLE. Any tick or `ss_edge` in that cycle is ignored, and `rollover` is 0.
  - RUN with `tick` and `ss_edge` in the same cycle: the tick is counted, then the state moves to PAUSE.
  - PAUSE or IDLE with `tick` and `ss_edge` in the same cycle: the tick is not counted and the state moves to RUN.
- Ticks arriving in IDLE or PAUSE are discarded, not queued.
- `start_stop` held high produces only one toggle.
- `clear` held high keeps the block in IDLE. An `ss_edge` coincident with `clear` is lost. The history flop still updates, so releasing `clear` while `start_stop` is still high does not start the block.

## Timing
- Reset values:
  - Outputs: `running`=0, all digits 0, `rollover`=0.
  - Internal: FSM IDLE, all synchroniser and history flops 0.
- Asserting `rst` mid-count clears everything immediately, independent of `clock`.
- A `clk_in` rising edge that precedes `clock` edge k by at least setup time causes the count to update at edge k+`SYNC_STAGES`. That is k+2 at the default, with ±1 cycle of metastability uncertainty.
- `ss_edge` latency: `start_stop` high at edge k gives `running` = 1 after edge k.
- `clear` acts at the edge where it is sampled high; digits read 0 after that edge.
- `rollover` is registered. It is high for exactly the cycle after the edge on which the count wrapped.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset then run: pulse `start_stop`, drive 75 `clk_in` cycles (each phase 8 `clock` cycles) → 01:15, `running`=1, `rollover` never asserted.
- Pause: in RUN at 00:10, pulse `start_stop`, drive 5 `clk_in` cycles → still 00:10, `running`=0. Pulse again and drive 3 more cycles → 00:13.
- Wrap: preload to 59:58 by counting, drive 2 `clk_in` rising edges → 59:59 then 00:00, `rollover` high for exactly 1 cycle, `running` stays 1.
- Simultaneous events: in RUN at 00:04, align `tick` and `ss_edge` in the same cycle → 00:05 and PAUSE. Repeat from PAUSE with the same alignment → 00:05 held and RUN.
- Clear priority: at 03:27 in RUN, raise `clear` in the same cycle as a tick and a `start_stop` edge → 00:00, IDLE, `running`=0, `rollover`=0. Hold `start_stop` high and release `clear` → stays IDLE.
- Async reset mid-count: at 12:34, pulse `rst` between `clock` edges → all outputs 0 before the next edge. Ticks are ignored until a `start_stop` edge.
